multiple_keypress_decoder: RTL and testbench

Receive-side counterpart of the keypress encoder. It accepts a byte stream, typically from the UART RX datapath, with a one-cycle valid strobe. Each byte is decoded back into the four key lines (a/s/d/w), including the four two-key diagonal codes. Decoded keys are held for a programmable time window, so that a remote operator holding a key, with the sender repeating the code, produces a continuous press on the local board.

---
 rtl/multiple_keypress_decoder.sv | 144 ++++++++++++++
 tb/tb_multiple_keypress_decoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/multiple_keypress_decoder.sv
// ---------------------------------------------------------------------------
// multiple_keypress_decoder
//
// Receive-side decoder for the keypress link. Each byte that arrives with a
// one-cycle valid strobe is mapped back onto the four key lines (a/s/d/w).
// The map includes the four two-key diagonals. A decoded pattern is held for
// HOLD_CYCLES cycles after the last valid code. While the sender keeps
// repeating a code, the local key therefore stays continuously pressed.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          synchronous active-high reset
//   i_data         received code (bits above 7 must be zero)
//   i_valid        one-cycle strobe qualifying i_data
//   o_key_a/s/d/w  decoded key lines
//   o_key_pressed  registered OR of the key lines
//   o_code_error   one-cycle pulse for an undefined code
//   o_err_count    saturating count of undefined codes
// ---------------------------------------------------------------------------
module multiple_keypress_decoder #(
  parameter int DATA_WIDTH  = 8,
  parameter int HOLD_CYCLES = 1000,
  parameter int TIMER_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_key_a,
  output logic                  o_key_s,
  output logic                  o_key_d,
  output logic                  o_key_w,
  output logic                  o_key_pressed,
  output logic                  o_code_error,
  output logic [7:0]            o_err_count
);

  typedef enum logic {IDLE, HOLD} state_e;

  localparam logic [TIMER_WIDTH-1:0] RELOAD = TIMER_WIDTH'(HOLD_CYCLES - 1);

  // Result layout: {is_key, is_null, w, d, s, a}
  function automatic logic [5:0] decode(input logic [DATA_WIDTH-1:0] code);
    logic [DATA_WIDTH-1:0] upper;
    logic [5:0]            res;
    upper = code >> 8;
    res   = 6'b00_0000;
    if (upper == '0) begin
      case (code[7:0])
        8'h61:   res = 6'b10_0001; // a
        8'h73:   res = 6'b10_0010; // s
        8'h64:   res = 6'b10_0100; // d
        8'h77:   res = 6'b10_1000; // w
        8'h23:   res = 6'b10_1001; // w+a
        8'h24:   res = 6'b10_1100; // w+d
        8'h25:   res = 6'b10_0011; // s+a
        8'h26:   res = 6'b10_0110; // s+d
        8'h00:   res = 6'b01_0000; // release
        default: res = 6'b00_0000;
      endcase
    end
    return res;
  endfunction

  state_e                 state_q, state_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [3:0]             keys_q,  keys_d;   // {w, d, s, a}
  logic                   pressed_q;
  logic                   err_q,   err_d;
  logic [7:0]             cnt_q,   cnt_d;

  logic [5:0]             dec;
  logic                   is_key;
  logic                   is_null;
  logic [3:0]             pattern;

  always_comb begin
    dec     = decode(i_data);
    is_key  = dec[5];
    is_null = dec[4];
    pattern = dec[3:0];

    state_d = state_q;
    timer_d = timer_q;
    keys_d  = keys_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    // Hold-window countdown. Undefined codes fall through to it, so they
    // neither stall the timer nor prevent the release.
    if (state_q == HOLD) begin
      if (timer_q != '0) begin
        timer_d = timer_q - TIMER_WIDTH'(1);
      end else begin
        keys_d  = 4'b0000;
        state_d = IDLE;
      end
    end

    // A valid code overrides the countdown. This includes the edge where the
    // timer expires, so a repeated code leaves no release gap.
    if (i_valid) begin
      if (is_key) begin
        keys_d  = pattern;
        timer_d = RELOAD;
        state_d = HOLD;
      end else if (is_null) begin
        keys_d  = 4'b0000;
        timer_d = '0;
        state_d = IDLE;
      end else begin
        err_d = 1'b1;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      keys_q    <= 4'b0000;
      pressed_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      keys_q    <= keys_d;
      pressed_q <= |keys_d;   // registered from keys_d to stay aligned with keys_q
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_key_a       = keys_q[0];
  assign o_key_s       = keys_q[1];
  assign o_key_d       = keys_q[2];
  assign o_key_w       = keys_q[3];
  assign o_key_pressed = pressed_q;
  assign o_code_error  = err_q;
  assign o_err_count   = cnt_q;

endmodule

// File: tb/tb_multiple_keypress_decoder.sv
// ---------------------------------------------------------------------------
// tb_multiple_keypress_decoder
//
// Directed bench for multiple_keypress_decoder. The DUT is built with
// DATA_WIDTH=9 and HOLD_CYCLES=4. Inputs change 1 ns after the rising edge,
// and outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_multiple_keypress_decoder;

  localparam int DW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data;
  logic          valid;
  logic          key_a, key_s, key_d, key_w;
  logic          pressed, code_err;
  logic [7:0]    err_cnt;

  int checks = 0;
  int errors = 0;

  multiple_keypress_decoder #(
    .DATA_WIDTH (DW),
    .HOLD_CYCLES(4),
    .TIMER_WIDTH(16)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data       (data),
    .i_valid      (valid),
    .o_key_a      (key_a),
    .o_key_s      (key_s),
    .o_key_d      (key_d),
    .o_key_w      (key_w),
    .o_key_pressed(pressed),
    .o_code_error (code_err),
    .o_err_count  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] keys();
    return {key_w, key_d, key_s, key_a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    valid = 1'b1;
    data  = d;
    step();
    valid = 1'b0;
    data  = '0;
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b1;
    data  = 9'h061;
    step();
    step();
    // 1. reset wins over a simultaneous valid code
    chk("rst_keys", 32'(keys()), 32'h0);
    chk("rst_pressed", 32'(pressed), 32'h0);
    chk("rst_err", 32'(code_err), 32'h0);
    chk("rst_cnt", 32'(err_cnt), 32'h0);
    rst   = 1'b0;
    valid = 1'b0;
    data  = '0;
    step();

    // 2. single 'a' held for exactly 4 cycles
    send(9'h061);
    for (int i = 0; i < 4; i++) begin
      chk("a_hold", 32'(keys()), 32'h1);
      chk("a_pressed", 32'(pressed), 32'h1);
      step();
    end
    chk("a_release", 32'(keys()), 32'h0);
    chk("a_pressed_rel", 32'(pressed), 32'h0);

    // 3. diagonal w+a replaced by w two cycles later
    send(9'h023);
    chk("wa_1", 32'(keys()), 32'h9);
    step();
    chk("wa_2", 32'(keys()), 32'h9);
    send(9'h077);
    for (int i = 0; i < 4; i++) begin
      chk("w_hold", 32'(keys()), 32'h8);
      step();
    end
    chk("w_release", 32'(keys()), 32'h0);

    // other diagonals
    send(9'h024);
    chk("wd", 32'(keys()), 32'hC);
    send(9'h025);
    chk("sa", 32'(keys()), 32'h3);
    send(9'h026);
    chk("sd", 32'(keys()), 32'h6);
    chk("diag_no_err", 32'(code_err), 32'h0);

    // 4. null code releases immediately
    send(9'h073);
    chk("s_set", 32'(keys()), 32'h2);
    step();
    send(9'h000);
    chk("null_rel", 32'(keys()), 32'h0);
    chk("null_pressed", 32'(pressed), 32'h0);
    chk("null_no_err", 32'(code_err), 32'h0);
    send(9'h000);
    chk("null_idle", 32'(keys()), 32'h0);
    chk("null_idle_err", 32'(code_err), 32'h0);

    // 5. undefined codes while holding d
    send(9'h064);
    send(9'h041);
    chk("undef_err", 32'(code_err), 32'h1);
    chk("undef_cnt", 32'(err_cnt), 32'h1);
    chk("undef_keys", 32'(keys()), 32'h4);
    step();
    chk("undef_pulse_end", 32'(code_err), 32'h0);
    chk("undef_keys2", 32'(keys()), 32'h4);
    send(9'h161);   // upper bit set makes 'a' undefined
    chk("hi_err", 32'(code_err), 32'h1);
    chk("hi_cnt", 32'(err_cnt), 32'h2);
    chk("hi_keys", 32'(keys()), 32'h4);
    step();
    chk("hold_expired", 32'(keys()), 32'h0);

    valid = 1'b1;
    data  = 9'h1FF;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 1) chk("b2b_err", 32'(code_err), 32'h1);
    end
    chk("sat_cnt", 32'(err_cnt), 32'hFF);
    chk("sat_err", 32'(code_err), 32'h1);
    valid = 1'b0;
    data  = 9'h061;   // ignored while valid is low
    step();
    chk("sat_err_end", 32'(code_err), 32'h0);
    chk("ignore_data", 32'(keys()), 32'h0);
    chk("sat_hold", 32'(err_cnt), 32'hFF);

    // 6. repeat on the timer==0 cycle leaves no gap
    send(9'h064);
    for (int i = 0; i < 3; i++) begin
      chk("d_first", 32'(key_d), 32'h1);
      step();
    end
    chk("d_t0", 32'(key_d), 32'h1);
    send(9'h064);
    for (int i = 0; i < 4; i++) begin
      chk("d_again", 32'(key_d), 32'h1);
      chk("d_again_pr", 32'(pressed), 32'h1);
      step();
    end
    chk("d_release", 32'(key_d), 32'h0);

    // reset mid-hold
    send(9'h064);
    step();
    chk("d_pre_rst", 32'(key_d), 32'h1);
    rst = 1'b1;
    step();
    chk("midrst_keys", 32'(keys()), 32'h0);
    chk("midrst_pressed", 32'(pressed), 32'h0);
    chk("midrst_cnt", 32'(err_cnt), 32'h0);
    rst = 1'b0;
    step();
    chk("post_rst", 32'(keys()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
